// File: rtl/accum_alu_n.sv
// accum_alu_n: WIDTH-bit accumulator ALU with 16 opcodes, C/V/Z/N flags and an
// accumulator that can stand in for operand A. Shifts and rotates move one bit
// per clock, and the valid/ready handshake holds the source off while a shift runs.
//
// Ports
//   Clk, Reset          rising-edge clock, synchronous active-high reset
//   in_valid, in_ready  request handshake; transfer = in_valid & in_ready
//   op, src_sel, a, b   opcode, A-source select (1: acc), operands (b[SHW-1:0] = shift amount)
//   cin                 carry-in (ADD) / borrow-in (SUB)
//   out_valid           one-cycle pulse when r and the flags hold a new result
//   r, cf, of, zf, nf   result and carry/borrow, overflow, zero, negative flags
//   busy                multi-cycle shift in progress
module accum_alu_n #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             src_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] r,
  output logic             cf,
  output logic             of,
  output logic             zf,
  output logic             nf,
  output logic             busy
);

  localparam int unsigned W1 = WIDTH + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   cnt;
  logic [2:0]       sh_op;   // low opcode bits; every shift/rotate has op[3] = 1
  logic             sh_of;   // sticky sign-change flag for SLA

  logic [WIDTH-1:0] opa;
  logic [SHW-1:0]   k;
  logic [W1-1:0]    sum_add;
  logic [W1-1:0]    diff_sub;
  logic [W1-1:0]    diff_cmp;
  logic [WIDTH-1:0] inc_r;
  logic [WIDTH-1:0] dec_r;

  logic [WIDTH-1:0] alu_r;
  logic [WIDTH-1:0] alu_zn;   // value the Z/N flags are taken from
  logic             alu_cf;
  logic             alu_of;
  logic             alu_accw; // result is written to acc

  logic [WIDTH-1:0] step_w;
  logic             step_out;
  logic             step_flip;

  // Single-cycle datapath: all non-shift ops, and shifts with k = 0
  always_comb begin
    opa      = src_sel ? acc : a;
    k        = b[SHW-1:0];
    sum_add  = {1'b0, opa} + {1'b0, b} + W1'(cin);
    diff_sub = {1'b0, opa} - {1'b0, b} - W1'(cin);
    diff_cmp = {1'b0, opa} - {1'b0, b};
    inc_r    = opa + WIDTH'(1);
    dec_r    = opa - WIDTH'(1);

    alu_r    = opa;
    alu_cf   = 1'b0;
    alu_of   = 1'b0;
    alu_accw = 1'b1;
    case (op)
      4'h0: begin
        alu_r  = sum_add[WIDTH-1:0];
        alu_cf = sum_add[WIDTH];
        alu_of = (opa[WIDTH-1] == b[WIDTH-1]) && (alu_r[WIDTH-1] != opa[WIDTH-1]);
      end
      4'h1: begin
        alu_r  = diff_sub[WIDTH-1:0];
        alu_cf = diff_sub[WIDTH];
        alu_of = (opa[WIDTH-1] != b[WIDTH-1]) && (alu_r[WIDTH-1] != opa[WIDTH-1]);
      end
      4'h2: begin
        alu_r    = opa;
        alu_cf   = diff_cmp[WIDTH];
        alu_of   = (opa[WIDTH-1] != b[WIDTH-1]) && (diff_cmp[WIDTH-1] != opa[WIDTH-1]);
        alu_accw = 1'b0;
      end
      4'h3: alu_r = opa & b;
      4'h4: alu_r = opa | b;
      4'h5: alu_r = ~opa;
      4'h6: begin
        alu_r  = inc_r;
        alu_cf = (opa == {WIDTH{1'b1}});
        alu_of = !opa[WIDTH-1] && inc_r[WIDTH-1];
      end
      4'h7: begin
        alu_r  = dec_r;
        alu_cf = (opa == '0);
        alu_of = opa[WIDTH-1] && !dec_r[WIDTH-1];
      end
      default: alu_r = opa; // shift/rotate by 0: A passes through, cf = of = 0
    endcase
    alu_zn = (op == 4'h2) ? diff_cmp[WIDTH-1:0] : alu_r;
  end

  // One-bit shift/rotate step on the work register
  always_comb begin
    step_w    = work;
    step_out  = 1'b0;
    step_flip = 1'b0;
    case (sh_op)
      3'd0: begin step_w = {work[WIDTH-2:0], 1'b0};         step_out = work[WIDTH-1]; end
      3'd1: begin step_w = {work[WIDTH-2:0], 1'b1};         step_out = work[WIDTH-1]; end
      3'd2: begin step_w = {1'b0, work[WIDTH-1:1]};         step_out = work[0];       end
      3'd3: begin step_w = {1'b1, work[WIDTH-1:1]};         step_out = work[0];       end
      3'd4: begin
        step_w    = {work[WIDTH-2:0], 1'b0};
        step_out  = work[WIDTH-1];
        step_flip = work[WIDTH-1] ^ work[WIDTH-2];  // sign bit after the step differs
      end
      3'd5: begin step_w = {work[WIDTH-1], work[WIDTH-1:1]}; step_out = work[0];       end
      3'd6: begin step_w = {work[WIDTH-2:0], work[WIDTH-1]}; step_out = work[WIDTH-1]; end
      3'd7: begin step_w = {work[0], work[WIDTH-1:1]};       step_out = work[0];       end
    endcase
  end

  // Control FSM, result and flag registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      acc       <= '0;
      work      <= '0;
      cnt       <= '0;
      sh_op     <= '0;
      sh_of     <= 1'b0;
      r         <= '0;
      cf        <= 1'b0;
      of        <= 1'b0;
      zf        <= 1'b0;
      nf        <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (op[3] && (k != '0)) begin
              state    <= SHIFT;
              work     <= opa;
              cnt      <= k;
              sh_op    <= op[2:0];
              sh_of    <= 1'b0;
              busy     <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              r         <= alu_r;
              cf        <= alu_cf;
              of        <= alu_of;
              zf        <= (alu_zn == '0);
              nf        <= alu_zn[WIDTH-1];
              out_valid <= 1'b1;
              // acc updates on the same edge as r, so a back-to-back src_sel=1 op sees it
              if (alu_accw) acc <= alu_r;
            end
          end
        end
        SHIFT: begin
          work  <= step_w;
          cnt   <= cnt - SHW'(1);
          sh_of <= sh_of | step_flip;
          if (cnt == SHW'(1)) begin
            r         <= step_w;
            cf        <= step_out;
            of        <= sh_of | step_flip;
            zf        <= (step_w == '0);
            nf        <= step_w[WIDTH-1];
            acc       <= step_w;
            out_valid <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_alu_n.sv
// Directed self-checking bench for accum_alu_n at WIDTH = 8.
module tb_accum_alu_n;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic       src_sel;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_valid;
  logic [7:0] r;
  logic       cf, of, zf, nf;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  // {out_valid, in_ready, busy, r, cf, of, zf, nf}
  logic [14:0] obs;
  assign obs = {out_valid, in_ready, busy, r, cf, of, zf, nf};

  accum_alu_n #(.WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src_sel(src_sel), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .r(r), .cf(cf), .of(of), .zf(zf), .nf(nf), .busy(busy)
  );

  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Present one request and let it transfer on the next edge (block must be idle)
  task automatic issue(input logic [3:0] o, input logic s, input logic [7:0] av,
                       input logic [7:0] bv, input logic c);
    op = o; src_sel = s; a = av; b = bv; cin = c; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Reference: returns {r, cf, of, zf, nf}
  function automatic logic [11:0] model(input logic [3:0] o, input logic [7:0] av,
                                        input logic [7:0] bv, input logic c);
    int ua, ub, sa, sb, ci, t, st, k;
    logic [7:0] w, res, zn;
    logic fc, fo, s0;
    ua = int'(av); ub = int'(bv); ci = c ? 1 : 0;
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    fc = 1'b0; fo = 1'b0; t = 0; res = av;
    k = ub % 8; w = av;
    case (o)
      4'h0: begin t = ua + ub + ci; st = sa + sb + ci; res = 8'(t);
                  fc = (t > 255); fo = (st > 127) || (st < -128); end
      4'h1: begin t = ua - ub - ci; st = sa - sb - ci; res = 8'(t);
                  fc = (t < 0); fo = (st > 127) || (st < -128); end
      4'h2: begin t = ua - ub; st = sa - sb; res = av;
                  fc = (t < 0); fo = (st > 127) || (st < -128); end
      4'h3: res = av & bv;
      4'h4: res = av | bv;
      4'h5: res = ~av;
      4'h6: begin t = ua + 1; res = 8'(t); fc = (t > 255); fo = (sa + 1 > 127); end
      4'h7: begin t = ua - 1; res = 8'(t); fc = (t < 0); fo = (sa - 1 < -128); end
      default: begin
        for (int i = 0; i < k; i++) begin
          s0 = w[7];
          case (o)
            4'h8, 4'h9, 4'hC: begin fc = w[7]; w = {w[6:0], (o == 4'h9)}; end
            4'hA, 4'hB:       begin fc = w[0]; w = {(o == 4'hB), w[7:1]}; end
            4'hD:             begin fc = w[0]; w = {w[7], w[7:1]}; end
            4'hE:             begin fc = w[7]; w = {w[6:0], w[7]}; end
            default:          begin fc = w[0]; w = {w[0], w[7:1]}; end
          endcase
          if (o == 4'hC && w[7] != s0) fo = 1'b1;
        end
        res = w;
      end
    endcase
    zn = (o == 4'h2) ? 8'(t) : res;
    return {res, fc, fo, (zn == 8'h00), zn[7]};
  endfunction

  task automatic test_reset;
    Reset = 1'b1; in_valid = 1'b0; op = 4'h0; src_sel = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    n_checks++;
    if (obs !== {1'b0, 1'b1, 1'b0, 8'h00, 4'b0000}) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", obs, {1'b0, 1'b1, 1'b0, 8'h00, 4'b0000});
    end
  endtask

  task automatic test_arith;
    logic [14:0] exp_v;
    issue(4'h0, 1'b0, 8'hFF, 8'h01, 1'b0);
    exp_v = {3'b110, 8'h00, 4'b1010};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL add_ff_01: got %h want %h", obs, exp_v); end
    issue(4'h1, 1'b0, 8'h80, 8'h01, 1'b0);
    exp_v = {3'b110, 8'h7F, 4'b0100};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL sub_80_01: got %h want %h", obs, exp_v); end
    tick();
    exp_v = {3'b010, 8'h7F, 4'b0100};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL result_hold: got %h want %h", obs, exp_v); end
    issue(4'h0, 1'b0, 8'h7F, 8'h00, 1'b1);
    exp_v = {3'b110, 8'h80, 4'b0101};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL add_cin: got %h want %h", obs, exp_v); end
    issue(4'h1, 1'b0, 8'h00, 8'h00, 1'b1);
    exp_v = {3'b110, 8'hFF, 4'b1001};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL sub_borrow_in: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_back_to_back;
    logic [14:0] exp_v;
    op = 4'h0; src_sel = 1'b0; a = 8'h05; b = 8'h00; cin = 1'b0; in_valid = 1'b1;
    tick();
    exp_v = {3'b110, 8'h05, 4'b0000};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL b2b_first: got %h want %h", obs, exp_v); end
    src_sel = 1'b1; a = 8'hAA; b = 8'h03;
    tick();
    in_valid = 1'b0;
    exp_v = {3'b110, 8'h08, 4'b0000};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL b2b_forward: got %h want %h", obs, exp_v); end
    issue(4'h2, 1'b0, 8'h03, 8'h05, 1'b1);
    exp_v = {3'b110, 8'h03, 4'b1001};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL cmp_03_05: got %h want %h", obs, exp_v); end
    issue(4'h0, 1'b1, 8'h55, 8'h00, 1'b0);
    exp_v = {3'b110, 8'h08, 4'b0000};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL cmp_keeps_acc: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_shift;
    logic [14:0] exp_v;
    issue(4'hD, 1'b0, 8'h90, 8'h03, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs[14:12] !== 3'b001) begin
        n_fail++; $display("FAIL sra_busy_cycle%0d: got %b want %b", i, obs[14:12], 3'b001);
      end
      tick();
    end
    exp_v = {3'b110, 8'hF2, 4'b0001};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL sra_90_3: got %h want %h", obs, exp_v); end
    issue(4'hC, 1'b0, 8'h40, 8'h02, 1'b0);
    tick(); tick();
    exp_v = {3'b110, 8'h00, 4'b1110};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL sla_40_2: got %h want %h", obs, exp_v); end
    issue(4'hE, 1'b0, 8'h81, 8'h01, 1'b0);
    tick();
    exp_v = {3'b110, 8'h03, 4'b1000};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL rol_81_1: got %h want %h", obs, exp_v); end
    issue(4'hF, 1'b0, 8'h01, 8'h00, 1'b0);
    exp_v = {3'b110, 8'h01, 4'b0000};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL ror_k0: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_stall;
    logic [14:0] exp_v;
    issue(4'hA, 1'b0, 8'hF0, 8'h02, 1'b0);
    op = 4'h0; src_sel = 1'b0; a = 8'h01; b = 8'h01; cin = 1'b0; in_valid = 1'b1;
    tick();
    n_checks++;
    if (obs[14:12] !== 3'b001) begin n_fail++; $display("FAIL stall_busy: got %b want %b", obs[14:12], 3'b001); end
    tick();
    exp_v = {3'b110, 8'h3C, 4'b0000};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL stall_srl: got %h want %h", obs, exp_v); end
    tick();
    in_valid = 1'b0;
    exp_v = {3'b110, 8'h02, 4'b0000};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL stall_held_add: got %h want %h", obs, exp_v); end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_single: got %b want %b", out_valid, 1'b0); end
  endtask

  task automatic test_reset_abort;
    logic [14:0] exp_v;
    int hits;
    issue(4'h8, 1'b0, 8'h01, 8'h07, 1'b0);
    tick(); tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    exp_v = {3'b010, 8'h00, 4'b0000};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL abort_state: got %h want %h", obs, exp_v); end
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid === 1'b1) hits++;
    end
    n_checks++;
    if (hits !== 0) begin n_fail++; $display("FAIL abort_no_result: got %0d pulses want 0", hits); end
    issue(4'h0, 1'b1, 8'h77, 8'h00, 1'b0);
    exp_v = {3'b110, 8'h00, 4'b0010};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL abort_acc_clear: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_sweep;
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic [11:0] exp_v;
    int guard;
    va[0] = 8'h09; va[1] = 8'h0A; va[2] = 8'h07;
    vb[0] = 8'h01; vb[1] = 8'h05; vb[2] = 8'h0C;
    for (int j = 0; j < 3; j++) begin
      for (int o = 0; o < 16; o++) begin
        exp_v = model(4'(o), va[j], vb[j], 1'b0);
        issue(4'(o), 1'b0, va[j], vb[j], 1'b0);
        guard = 0;
        while (out_valid !== 1'b1 && guard < 20) begin
          tick();
          guard++;
        end
        n_checks++;
        if (guard >= 20) begin
          n_fail++; $display("FAIL sweep_timeout op=%h a=%h b=%h: no out_valid within 20 cycles", o, va[j], vb[j]);
        end else if (obs[11:0] !== exp_v) begin
          n_fail++; $display("FAIL sweep op=%h a=%h b=%h: got %h want %h", o, va[j], vb[j], obs[11:0], exp_v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_shift();
    test_stall();
    test_reset_abort();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
